// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: game-state controller and 1 Hz timebase for the score display.
//
// Each raw button passes through a two-flop synchroniser and a debouncer. The
// rising edge of the debounced level is registered into a one-cycle press.
// The presses and the collision flag drive the IDLE/RUNNING/PAUSED/OVER FSM.
// A divider counter advances only while RUNNING and produces clk_1Hz.
//
// Optional feature macro: GAME_TIMER_PAUSE_EN builds the pause button path.
// Without it, btn_pause is ignored and PAUSED is unreachable.
//
// Parameters:
//   CLK_FREQ_HZ     board-clock cycles per clk_1Hz period (even, >= 4)
//   DEBOUNCE_CYCLES stable cycles needed to accept a button level (>= 1)
// Ports:
//   clk_100MHz  in   board clock, rising edge
//   reset       in   asynchronous, active-high
//   btn_start   in   raw start button
//   btn_pause   in   raw pause button
//   collision   in   synchronous level, ends the game
//   clk_1Hz     out  registered square wave, toggles only while RUNNING
//   status      out  registered, 1 while RUNNING
//   game_over   out  registered, 1 while OVER
//   score_clear out  registered one-cycle pulse on each new game
module game_timer_ctrl #(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_pause,
  input  logic collision,
  output logic clk_1Hz,
  output logic status,
  output logic game_over,
  output logic score_clear
);

`ifdef GAME_TIMER_PAUSE_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam int unsigned CNT_W = $clog2(CLK_FREQ_HZ);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVER} state_t;

  // Button index 0 is start; index 1 (when built) is pause.
  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync2_q;
  logic [NB-1:0]   db_q, db_d, db_dly_q, press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];
  logic            start_press, pause_press;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            clk_q, clk_d;
  logic            status_q, status_d;
  logic            over_q, over_d;
  logic            clear_q, clear_d;

`ifdef GAME_TIMER_PAUSE_EN
  assign btn_raw     = {btn_pause, btn_start};
  assign pause_press = press_q[1];
`else
  logic unused_btn_pause;
  assign unused_btn_pause = btn_pause;
  assign btn_raw          = btn_start;
  assign pause_press      = 1'b0;
`endif
  assign start_press = press_q[0];

  // Debounce: count consecutive cycles the synchronised level differs from the
  // accepted level; any return to the accepted level restarts the count.
  always_comb begin
    for (int i = 0; i < int'(NB); i++) begin
      db_cnt_d[i] = '0;
      db_d[i]     = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    press_d = db_q & ~db_dly_q;
  end

  // Game FSM and divider.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    clear_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        cnt_d = '0;
        if (start_press) begin
          state_d = S_RUN;
          clear_d = 1'b1;
        end
      end
      S_RUN: begin
        if (collision) begin
          state_d = S_OVER;
          cnt_d   = '0;
        end else begin
          if (pause_press) state_d = S_PAUSE;
          // The cycle carrying the pause press still counts as running time.
          cnt_d = (cnt_q == CNT_W'(CLK_FREQ_HZ - 1)) ? '0 : cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CLK_FREQ_HZ - 1)) begin
            clk_d = 1'b1;
          end else if (cnt_q == CNT_W'(CLK_FREQ_HZ / 2 - 1)) begin
            clk_d = 1'b0;
          end
        end
      end
      S_PAUSE: begin
        if (pause_press || start_press) state_d = S_RUN;
      end
    endcase
    if (state_d == S_IDLE || state_d == S_OVER) clk_d = 1'b0;
    status_d = (state_d == S_RUN);
    over_d   = (state_d == S_OVER);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
      db_cnt_q <= '{default: '0};
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      status_q <= 1'b0;
      over_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      status_q <= status_d;
      over_q   <= over_d;
      clear_q  <= clear_d;
    end
  end

  assign clk_1Hz     = clk_q;
  assign status      = status_q;
  assign game_over   = over_q;
  assign score_clear = clear_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Testbench for game_timer_ctrl (CLK_FREQ_HZ=10, DEBOUNCE_CYCLES=4).
// A cycle-level reference model derives presses from the raw button history
// and the game state/timebase from elapsed running time; expected outputs are
// queued per cycle and checked by an independent monitor.
module tb_game_timer_ctrl;
  localparam int N    = 10;
  localparam int D    = 4;
  localparam int MAXC = 6000;
`ifdef GAME_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_start = 1'b0;
  logic btn_pause = 1'b0;
  logic collision = 1'b0;
  logic clk_1Hz, status, game_over, score_clear;

  game_timer_ctrl #(.CLK_FREQ_HZ(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .collision  (collision),
    .clk_1Hz    (clk_1Hz),
    .status     (status),
    .game_over  (game_over),
    .score_clear(score_clear)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];   // {status, game_over, score_clear, clk_1Hz}
  bit mon_en = 1'b0;

  // Model: per-cycle raw button history and debounced levels for this epoch.
  bit rs[MAXC], rp[MAXC], ds[MAXC], dp[MAXC];
  int k;
  int m_state;   // 0 idle, 1 running, 2 paused, 3 over
  int m_run;     // running cycles elapsed since the game started
  bit m_sc;

  function automatic bit sync2(input bit which, input int c);
    if (c < 2) return 1'b0;
    return which ? rp[c-2] : rs[c-2];
  endfunction

  function automatic bit db_at(input bit which, input int j);
    return which ? dp[j] : ds[j];
  endfunction

  // Level changes once the last D synchronised samples all show the new level.
  function automatic bit next_db(input bit which, input int j);
    bit cur;
    cur = db_at(which, j - 1);
    if (j - D < 0) return cur;
    for (int i = j - D; i < j; i++)
      if (sync2(which, i) == cur) return cur;
    return !cur;
  endfunction

  function automatic bit press_at(input bit which, input int c);
    if (c < 2) return 1'b0;
    return db_at(which, c - 1) && !db_at(which, c - 2);
  endfunction

  function automatic logic [3:0] model_out();
    bit ck;
    ck = (m_state == 1 || m_state == 2) && m_run >= N && (m_run % N) < N / 2;
    return {m_state == 1, m_state == 3, m_sc, ck};
  endfunction

  // Drive inputs for cycle k and queue the expected outputs of cycle k+1.
  task automatic drive_cycle(input bit bs, input bit bp, input bit col, input bit col_on_pause);
    bit ps, pp;
    int ns;
    if (k + 1 >= MAXC) begin
      tests++; fails++;
      $display("FAIL model_overflow cycle=%0d limit=%0d", k, MAXC);
      $fatal(1, "model history exhausted");
    end
    btn_start = bs;
    btn_pause = bp;
    rs[k] = bs;
    rp[k] = bp;
    ps = press_at(1'b0, k);
    pp = PAUSE_EN && press_at(1'b1, k);
    if (col_on_pause && pp) col = 1'b1;
    collision = col;
    ds[k+1] = next_db(1'b0, k + 1);
    dp[k+1] = next_db(1'b1, k + 1);
    ns = m_state;
    m_sc = 1'b0;
    case (m_state)
      0, 3: if (ps) begin ns = 1; m_run = 0; m_sc = 1'b1; end
      1: begin
        if (col) ns = 3;
        else if (pp) ns = 2;
        m_run++;
      end
      2: if (pp || ps) ns = 1;
      default: ns = 0;
    endcase
    m_state = ns;
    exp_q.push_back(model_out());
    k++;
  endtask

  task automatic tick(input bit bs, input bit bp, input bit col, input bit cop);
    @(posedge clk);
    #2;
    drive_cycle(bs, bp, col, cop);
  endtask

  task automatic start_epoch();
    @(posedge clk);
    #2;
    reset = 1'b0;
    k = 0;
    ds[0] = 1'b0;
    dp[0] = 1'b0;
    m_state = 0;
    m_run = 0;
    m_sc = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic reset_now(input string tag);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if ({status, game_over, score_clear, clk_1Hz} !== 4'b0000) begin
      fails++;
      $display("FAIL %s got=%b required=0000", tag, {status, game_over, score_clear, clk_1Hz});
    end
    exp_q.delete();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    collision = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_running(input int budget);
    int n;
    n = 0;
    while (m_state != 1 && n < budget) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    tests++;
    if (m_state != 1) begin
      fails++;
      $display("FAIL wait_running state=%0d required=1", m_state);
    end
  endtask

  task automatic run_random(input int cycles, input int col_rate);
    bit bs, bp;
    int seg_s, seg_p;
    bs = 1'b0; bp = 1'b0; seg_s = 0; seg_p = 0;
    for (int i = 0; i < cycles; i++) begin
      if (seg_s == 0) begin bs = 1'($urandom_range(0, 1)); seg_s = $urandom_range(1, 14); end
      if (seg_p == 0) begin bp = 1'($urandom_range(0, 1)); seg_p = $urandom_range(1, 14); end
      seg_s--;
      seg_p--;
      tick(bs, bp, $urandom_range(0, col_rate - 1) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  // Monitor: one expected word per cycle while enabled.
  initial begin
    logic [3:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        tests++;
        got = {status, game_over, score_clear, clk_1Hz};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow t=%0t got=%b", $time, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL outputs t=%0t {status,game_over,score_clear,clk_1Hz} got=%b required=%b",
                     $time, got, e);
          end
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({status, game_over, score_clear, clk_1Hz} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_state got=%b required=0000", {status, game_over, score_clear, clk_1Hz});
    end

    // Clean start press and a few clk_1Hz periods.
    start_epoch();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Pause, long wait, resume; without the pause path this must have no effect.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Collision raised in the same cycle as a pause press, then a new game.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    reset_now("reset_running");

    // Bouncing start button: no press may result.
    start_epoch();
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2) == 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    reset_now("reset_idle");

    // Reset while paused with clk_1Hz high (or while running without pause).
    start_epoch();
    wait_running(40);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (PAUSE_EN && !(m_state == 2 && model_out()[0]) && n < 400) begin
      tick(1'b0, (n % 12) < 6, 1'b0, 1'b0);
      n++;
    end
    reset_now("reset_paused");

    // Held button across reset release must be treated as a fresh press.
    start_epoch();
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    reset_now("reset_held");

    // Randomised play.
    start_epoch();
    run_random(3000, 80);
    reset_now("reset_random1");
    start_epoch();
    run_random(2500, 25);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Upstream control stage for the score display: turns raw start/pause buttons and a collision flag into the game state, and generates the `clk_1Hz` square wave and `status` level that the score display counts with. Runs entirely on the 100 MHz board clock. Also issues a one-cycle `score_clear` pulse at every new game so the display's score returns to 0.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: board-clock cycles per `clk_1Hz` period (N). Must be even and ≥ 4.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level (10 ms at 100 MHz). Must be ≥ 1.
- `clk_100MHz`  in  1  board clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `btn_start`  in  1  raw, asynchronous push-button, active-high.
- `btn_pause`  in  1  raw, asynchronous push-button, active-high.
- `collision`  in  1  synchronous level from game logic; high ends the game.
- `clk_1Hz`  out  1  registered square wave, period N cycles, 50 % duty, only toggles in RUNNING.
- `status`  out  1  registered; 1 exactly while state = RUNNING.
- `game_over`  out  1  registered; 1 exactly while state = OVER.
- `score_clear`  out  1  registered one-cycle pulse on every entry to RUNNING from IDLE or OVER.

## Operation
- Button path, per button: 2-flop synchroniser → debouncer. The debounce counter resets on any change of the synchronised level. When the same level has been held for `DEBOUNCE_CYCLES` cycles, the debounced level updates. A rising edge of the debounced level gives a one-cycle `press` pulse.
- FSM states: IDLE (reset), RUNNING, PAUSED, OVER.
  - IDLE: `start_press` → RUNNING, with `score_clear`.
  - RUNNING: `collision` → OVER. `pause_press` → PAUSED. `start_press` is ignored.
  - PAUSED: `pause_press` or `start_press` → RUNNING, without clear. `collision` is ignored.
  - OVER: `start_press` → RUNNING, with `score_clear`. `pause_press` is ignored.
- Simultaneous events in RUNNING: `collision` takes priority over `pause_press`.
- Divider counter, 0..N-1, `$clog2(N)` bits:
  - Loaded to 0 on entry to RUNNING from IDLE or OVER.
  - Increments and wraps N-1 → 0 while RUNNING.
  - Frozen while PAUSED; `clk_1Hz` holds its level.
  - Held at 0 in IDLE and OVER, with `clk_1Hz` forced to 0.
- `clk_1Hz` register, RUNNING only: set on the cycle the counter = N-1, cleared on the cycle the counter = N/2-1.
- Reset values: state IDLE, counter 0, debounced levels 0, all outputs 0.

## Timing
- Button latency: a raw edge held stable reaches `press` after 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles. A bounce shorter than `DEBOUNCE_CYCLES` produces no press.
- Entry to RUNNING: `press` at cycle t → state, `status` and `score_clear` are all visible at t+1. `score_clear` is low again at t+2.
- First `clk_1Hz` rising edge comes N cycles after `status` rises. Every following rising edge is N cycles after the previous one.
- Because `status` is 1 for the whole second before each `clk_1Hz` rise, a downstream sampler counts only full elapsed seconds.
- `collision` at cycle t → `status` = 0, `game_over` = 1 and `clk_1Hz` = 0 at t+1.
- Pause/resume keeps the phase: the total RUNNING cycles between `clk_1Hz` rises stays N.
- `reset` asserted mid-game: all outputs 0 asynchronously. After deassertion the block waits in IDLE for a fresh `start_press`.

## Configuration
- Macro `GAME_TIMER_PAUSE_EN`.
- Defined: the `btn_pause` synchroniser and debouncer are built and PAUSED is reachable as described above.
- Undefined: the pause path is not synthesised, `btn_pause` is ignored and PAUSED is unreachable. All other behaviour is identical.

## Test plan
All scenarios use `CLK_FREQ_HZ`=10 and `DEBOUNCE_CYCLES`=4.
- Reset, then hold `btn_start` high 10 cycles → `press` 7 cycles after the edge; `status`=1 and `score_clear`=1 for exactly 1 cycle; `clk_1Hz` rises 10 cycles later, high 5 / low 5.
- Toggle `btn_start` every 2 cycles for 20 cycles → no press; state stays IDLE; all outputs 0.
- RUNNING with counter at 3: pause press, wait 50 cycles, pause press → `status` low for the pause; the next `clk_1Hz` rise comes exactly 7 RUNNING cycles after resume.
- RUNNING: `collision` and `pause_press` in the same cycle → OVER next cycle, `game_over`=1, `clk_1Hz`=0; a later start press → RUNNING with `score_clear` pulse and the counter restarted at 0.
- Assert `reset` mid-PAUSED while `clk_1Hz`=1 → all outputs 0 within the same cycle; state IDLE after release.
- Build without `GAME_TIMER_PAUSE_EN`: hold `btn_pause` 20 cycles while RUNNING → `status` stays 1 and `clk_1Hz` period remains 10.
